// File: rtl/coffee_dispenser_pkg.sv
// Shared definitions for the coffee dispenser and the upstream coin FSM:
// state encodings, coin encodings, default timing and a timer sizing helper.
package coffee_pkg;

    // Dispenser FSM state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DROP     = 3'd1;
    localparam logic [2:0] ST_WAIT_CUP = 3'd2;
    localparam logic [2:0] ST_FILL     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    // Coin encodings used by the coin-acceptor FSM
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_10   = 2'd1;
    localparam logic [1:0] COIN_5    = 2'd2;

    // Default timing constants
    localparam int DEF_CUP_CYCLES  = 2;
    localparam int DEF_CUP_TIMEOUT = 16;
    localparam int DEF_FILL_CYCLES = 8;
    localparam int DEF_MAX_PENDING = 3;

    // Width of the pending-grant counter (holds up to 7)
    localparam int PEND_W = 3;

    // Bits needed to hold the largest reload value (phase length minus one)
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/coffee_dispenser_if.sv
// Signal bundle between the coin FSM / machine sensors (master side) and the
// dispenser (slave side).
//
// Grant protocol: coffee is a fire-and-forget pulse with no ready/back-pressure.
// Every cycle coffee is high at a rising edge is one purchased coffee; the
// dispenser either queues it (pending increments) or, when the queue is full,
// drops it and raises overflow for one cycle. state is a debug view of the FSM.
interface coffee_dispenser_if;
    import coffee_pkg::*;

    logic              coffee;
    logic              cup_present;
    logic              cup_drop;
    logic              valve_open;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              fault;
    logic [PEND_W-1:0] pending;
    logic [2:0]        state;

    modport master (
        output coffee, cup_present,
        input  cup_drop, valve_open, busy, done, overflow, fault, pending, state
    );

    modport slave (
        input  coffee, cup_present,
        output cup_drop, valve_open, busy, done, overflow, fault, pending, state
    );

endinterface

// File: rtl/coffee_dispenser_timer.sv
// Down-counter shared by the DROP, WAIT_CUP and FILL phases. Loading N-1 and
// counting down to zero keeps the FSM in a phase for exactly N cycles.
module dispense_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    // Reload on phase entry, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/coffee_dispenser.sv
// Brew sequencer downstream of the coin FSM. Queues grant pulses in a
// saturating counter and runs cup drop -> cup sense -> timed fill per grant.
// All outputs are registered decodes of the current state, so actuators move
// one cycle after the FSM decides. Faults latch until reset.
module coffee_dispenser
    import coffee_pkg::*;
#(
    parameter int CUP_CYCLES  = DEF_CUP_CYCLES,
    parameter int CUP_TIMEOUT = DEF_CUP_TIMEOUT,
    parameter int FILL_CYCLES = DEF_FILL_CYCLES,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic                clk,
    input  logic                reset,
    coffee_dispenser_if.slave   bus
);

    localparam int TW = timer_width(CUP_CYCLES, CUP_TIMEOUT, FILL_CYCLES);
    localparam logic [PEND_W-1:0] MAXP = PEND_W'(MAX_PENDING);

    logic [2:0]        state, next_state;
    logic [PEND_W-1:0] pending;
    logic              overflow_q;
    logic              cup_drop_q, valve_open_q, busy_q, done_q, fault_q;
    logic              tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0]     tmr_val;
    logic              grant, brew_done;

    assign grant     = bus.coffee;
    assign brew_done = (state == ST_DONE);

    dispense_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // Next-state and timer control; each phase reloads the timer on entry
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A new cup only drops once the previous one has been taken
                if ((pending != '0) && !bus.cup_present) begin
                    next_state = ST_DROP;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(CUP_CYCLES - 1);
                end
            end
            ST_DROP: begin
                if (tmr_expired) begin
                    next_state = ST_WAIT_CUP;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(CUP_TIMEOUT - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_CUP: begin
                if (bus.cup_present) begin
                    next_state = ST_FILL;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(FILL_CYCLES - 1);
                end else if (tmr_expired) begin
                    next_state = ST_FAULT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_FILL: begin
                if (!bus.cup_present) begin
                    next_state = ST_FAULT;
                end else if (tmr_expired) begin
                    next_state = ST_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_FAULT;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Saturating grant queue; a grant arriving with a completion nets to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (grant && !brew_done) begin
                if (pending >= MAXP) overflow_q <= 1'b1;
                else                 pending    <= pending + 1'b1;
            end else if (!grant && brew_done && (pending != '0)) begin
                pending <= pending - 1'b1;
            end
        end
    end

    // Registered Moore outputs; the valve also closes as soon as the cup is gone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cup_drop_q   <= 1'b0;
            valve_open_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            cup_drop_q   <= (state == ST_DROP);
            valve_open_q <= (state == ST_FILL) && bus.cup_present;
            busy_q       <= (state != ST_IDLE);
            done_q       <= (state == ST_DONE);
            fault_q      <= (state == ST_FAULT);
        end
    end

    assign bus.cup_drop   = cup_drop_q;
    assign bus.valve_open = valve_open_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.fault      = fault_q;
    assign bus.pending    = pending;
    assign bus.state      = state;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed bench for coffee_dispenser. Inputs change and outputs are sampled
// on the falling clock edge; t counts rising edges since the first grant.
module tb_coffee_dispenser;
    import coffee_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    coffee_dispenser_if dif();

    coffee_dispenser #(
        .CUP_CYCLES  (2),
        .CUP_TIMEOUT (16),
        .FILL_CYCLES (8),
        .MAX_PENDING (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        dif.coffee      = 1'b0;
        dif.cup_present = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        dif.coffee      = 1'b0;
        dif.cup_present = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({dif.cup_drop, dif.valve_open, dif.busy, dif.done, dif.overflow, dif.fault} !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 000000", {dif.cup_drop, dif.valve_open, dif.busy, dif.done, dif.overflow, dif.fault}); end
        n_checks++; if (dif.pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", dif.pending); end
        n_checks++; if (dif.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dif.state, ST_IDLE); end
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if ({dif.busy, dif.cup_drop, dif.pending} !== 5'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b want 00000", {dif.busy, dif.cup_drop, dif.pending}); end
    endtask

    task automatic test_single_brew();
        int first_drop = -1, n_drop = 0, first_valve = -1, n_valve = 0;
        int n_done = 0, done_at = -1, last_busy = -1;
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (dif.cup_drop)   begin n_drop++;  if (first_drop < 0)  first_drop  = t; end
            if (dif.valve_open) begin n_valve++; if (first_valve < 0) first_valve = t; end
            if (dif.done)       begin n_done++;  done_at = t; end
            if (dif.busy)       last_busy = t;
            if (t == 1) begin
                n_checks++; if (dif.pending !== 3'd1) begin n_fail++; $display("FAIL single_pending_up: got %0d want 1", dif.pending); end
                dif.coffee = 1'b0;
            end
            if (t == 6) dif.cup_present = 1'b1;
            if (t == 15) begin
                n_checks++; if (dif.pending !== 3'd1) begin n_fail++; $display("FAIL single_pending_hold: got %0d want 1", dif.pending); end
            end
        end
        n_checks++; if (first_drop !== 3)  begin n_fail++; $display("FAIL single_drop_latency: got %0d want 3", first_drop); end
        n_checks++; if (n_drop !== 2)      begin n_fail++; $display("FAIL single_drop_len: got %0d want 2", n_drop); end
        n_checks++; if (first_valve !== 8) begin n_fail++; $display("FAIL single_valve_start: got %0d want 8", first_valve); end
        n_checks++; if (n_valve !== 8)     begin n_fail++; $display("FAIL single_valve_len: got %0d want 8", n_valve); end
        n_checks++; if (n_done !== 1)      begin n_fail++; $display("FAIL single_done_count: got %0d want 1", n_done); end
        n_checks++; if (done_at !== 16)    begin n_fail++; $display("FAIL single_done_time: got %0d want 16", done_at); end
        n_checks++; if (last_busy !== 16)  begin n_fail++; $display("FAIL single_busy_end: got %0d want 16", last_busy); end
        n_checks++; if (dif.pending !== 3'd0) begin n_fail++; $display("FAIL single_pending_end: got %0d want 0", dif.pending); end
        dif.cup_present = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   arm = -1, n_ovf = 0, n_done = 0, max_pend = 0;
        logic prev_drop = 1'b0;
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (dif.overflow) n_ovf++;
            if (int'(dif.pending) > max_pend) max_pend = int'(dif.pending);
            if (t == 4) begin
                n_checks++; if (dif.pending !== 3'd3) begin n_fail++; $display("FAIL b2b_saturate: got %0d want 3", dif.pending); end
                n_checks++; if (dif.overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_overflow_pulse: got %b want 1", dif.overflow); end
                dif.coffee = 1'b0;
            end
            // Cup lands two samples after the dropper releases; taken away on done
            if (dif.done) begin
                n_done++;
                dif.cup_present = 1'b0;
            end
            if (prev_drop && !dif.cup_drop) begin
                arm = 2;
            end else if (arm > 0) begin
                arm--;
                if (arm == 0) begin
                    dif.cup_present = 1'b1;
                    arm = -1;
                end
            end
            prev_drop = dif.cup_drop;
        end
        n_checks++; if (n_ovf !== 1)    begin n_fail++; $display("FAIL b2b_overflow_count: got %0d want 1", n_ovf); end
        n_checks++; if (max_pend !== 3) begin n_fail++; $display("FAIL b2b_max_pending: got %0d want 3", max_pend); end
        n_checks++; if (n_done !== 3)   begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
        n_checks++; if (dif.pending !== 3'd0) begin n_fail++; $display("FAIL b2b_pending_end: got %0d want 0", dif.pending); end
        n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", dif.busy); end
    endtask

    task automatic test_coincident_grant();
        int n_ovf = 0;
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            if (dif.overflow) n_ovf++;
            if (t == 1)  dif.coffee = 1'b0;
            if (t == 6)  dif.cup_present = 1'b1;
            if (t == 15) dif.coffee = 1'b1;
            if (t == 16) begin
                n_checks++; if (dif.done !== 1'b1) begin n_fail++; $display("FAIL coinc_done: got %b want 1", dif.done); end
                n_checks++; if (dif.pending !== 3'd1) begin n_fail++; $display("FAIL coinc_pending: got %0d want 1", dif.pending); end
                dif.coffee = 1'b0;
            end
            if (t == 18) begin
                n_checks++; if ({dif.busy, dif.cup_drop} !== 2'b00) begin n_fail++; $display("FAIL coinc_wait_cup_removal: got %b want 00", {dif.busy, dif.cup_drop}); end
                dif.cup_present = 1'b0;
            end
            if (t == 19) begin
                n_checks++; if (dif.cup_drop !== 1'b0) begin n_fail++; $display("FAIL coinc_drop_early: got %b want 0", dif.cup_drop); end
            end
            if (t == 20) begin
                n_checks++; if (dif.cup_drop !== 1'b1) begin n_fail++; $display("FAIL coinc_next_drop: got %b want 1", dif.cup_drop); end
            end
        end
        n_checks++; if (n_ovf !== 0) begin n_fail++; $display("FAIL coinc_no_overflow: got %0d want 0", n_ovf); end
    endtask

    task automatic test_cup_timeout();
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            if (t == 1) dif.coffee = 1'b0;
            if (t == 20) begin
                n_checks++; if (dif.fault !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", dif.fault); end
            end
        end
        n_checks++; if (dif.fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b want 1", dif.fault); end
        n_checks++; if ({dif.busy, dif.cup_drop, dif.valve_open} !== 3'b100) begin n_fail++; $display("FAIL timeout_actuators: got %b want 100", {dif.busy, dif.cup_drop, dif.valve_open}); end
        n_checks++; if (dif.pending !== 3'd1) begin n_fail++; $display("FAIL timeout_pending: got %0d want 1", dif.pending); end
        dif.coffee = 1'b1;
        tick();
        tick();
        dif.coffee = 1'b0;
        n_checks++; if (dif.pending !== 3'd3) begin n_fail++; $display("FAIL fault_grants_counted: got %0d want 3", dif.pending); end
        n_checks++; if (dif.fault !== 1'b1) begin n_fail++; $display("FAIL fault_latched: got %b want 1", dif.fault); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({dif.fault, dif.busy, dif.pending} !== 5'b0) begin n_fail++; $display("FAIL fault_reset_clear: got %b want 00000", {dif.fault, dif.busy, dif.pending}); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if ({dif.fault, dif.busy, dif.pending} !== 5'b0) begin n_fail++; $display("FAIL fault_after_release: got %b want 00000", {dif.fault, dif.busy, dif.pending}); end
    endtask

    task automatic test_cup_pulled();
        int n_done = 0;
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (dif.done) n_done++;
            if (t == 1) dif.coffee = 1'b0;
            if (t == 6) dif.cup_present = 1'b1;
            if (t == 10) begin
                n_checks++; if (dif.valve_open !== 1'b1) begin n_fail++; $display("FAIL pulled_valve_before: got %b want 1", dif.valve_open); end
                dif.cup_present = 1'b0;
            end
            if (t == 11) begin
                n_checks++; if (dif.valve_open !== 1'b0) begin n_fail++; $display("FAIL pulled_valve_off: got %b want 0", dif.valve_open); end
            end
            if (t == 12) begin
                n_checks++; if (dif.fault !== 1'b1) begin n_fail++; $display("FAIL pulled_fault: got %b want 1", dif.fault); end
            end
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL pulled_no_done: got %0d want 0", n_done); end
        n_checks++; if (dif.pending !== 3'd1) begin n_fail++; $display("FAIL pulled_pending_kept: got %0d want 1", dif.pending); end
        n_checks++; if (dif.valve_open !== 1'b0) begin n_fail++; $display("FAIL pulled_valve_stays_off: got %b want 0", dif.valve_open); end
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        dif.coffee = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) dif.coffee = 1'b0;
            if (t == 6) dif.cup_present = 1'b1;
        end
        n_checks++; if (dif.valve_open !== 1'b1) begin n_fail++; $display("FAIL midfill_valve_on: got %b want 1", dif.valve_open); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (dif.valve_open !== 1'b0) begin n_fail++; $display("FAIL midfill_valve_async_off: got %b want 0", dif.valve_open); end
        n_checks++; if (dif.pending !== 3'd0) begin n_fail++; $display("FAIL midfill_pending_cleared: got %0d want 0", dif.pending); end
        dif.cup_present = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_checks++; if ({dif.busy, dif.valve_open, dif.cup_drop} !== 3'b000) begin n_fail++; $display("FAIL midfill_idle_after: got %b want 000", {dif.busy, dif.valve_open, dif.cup_drop}); end
    endtask

    initial begin
        reset           = 1'b0;
        dif.coffee      = 1'b0;
        dif.cup_present = 1'b0;
        test_reset();
        test_single_brew();
        test_back_to_back();
        test_coincident_grant();
        test_cup_timeout();
        test_cup_pulled();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
